redled_display_arbiter: RTL and testbench

- Shares the 18-bit red LED bank between three status requesters: cruise-state, speed-band and fault-warning.
- Fixed priority with a minimum hold time; optional per-requester blinking.
- Drives the red LED PIO's Avalon-MM slave port as a write-only master.
- Issues a single write to PIO register 0 only when the displayed pattern changes, so the LEDs never glitch and bus traffic stays minimal.

---
 rtl/redled_display_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_redled_display_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/redled_display_arbiter.sv
// redled_display_arbiter
// Shares the 18-bit red LED bank between three status requesters
// (0 = cruise-state, 1 = speed-band, 2 = fault-warning). A fixed-priority
// arbiter with a minimum hold time picks the owner, an optional blink
// engine gates the owner's pattern, and a two-state write FSM pushes the
// displayed pattern to PIO register 0 only when it differs from what the
// PIO currently holds (tracked in a shadow register).
module redled_display_arbiter #(
  parameter int BLINK_DIV   = 25000000,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req_valid,
  input  logic [17:0] req_pattern0,
  input  logic [17:0] req_pattern1,
  input  logic [17:0] req_pattern2,
  input  logic [2:0]  req_blink,
  output logic [2:0]  grant,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  output logic        busy
);

  // Counter widths: the blink counter must reach BLINK_DIV-1 and the hold
  // counter must hold HOLD_CYCLES-1. Both are kept at least one bit wide.
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;

  logic [2:0]          next_grant;
  logic                holder_valid;
  logic                grant_change;

  logic [HOLD_W-1:0]   hold_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_phase;

  logic [17:0]         sel_pattern;
  logic                sel_blink;
  logic [17:0]         displayed;
  logic [17:0]         shadow;
  logic                load_write;

  // Fixed priority pick: bit 0 wins, then bit 1, then bit 2.
  function automatic logic [2:0] pick_highest(input logic [2:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (v[0])      r = 3'b001;
    else if (v[1]) r = 3'b010;
    else if (v[2]) r = 3'b100;
    return r;
  endfunction

  // Next owner: re-arbitrate when idle, when the holder lets go, or once the
  // hold window has expired; otherwise the current holder keeps the bank.
  always_comb begin
    holder_valid = |(grant & req_valid);
    next_grant   = grant;
    if (!holder_valid || (hold_cnt == '0)) begin
      next_grant = pick_highest(req_valid);
    end
    grant_change = (next_grant != grant);
  end

  // Grant register; the hold window restarts on every change to a real owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= 3'b000;
      hold_cnt <= '0;
    end else begin
      grant <= next_grant;
      if (grant_change && (next_grant != 3'b000)) begin
        hold_cnt <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
    end
  end

  // Blink timebase; a new owner restarts it in the lit phase so its pattern
  // appears without waiting for the next half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (grant_change) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_ONE;
    end
  end

  // Pattern the LEDs should show right now: the owner's pattern, blanked
  // during the dark blink phase if that owner asked to blink.
  always_comb begin
    sel_pattern = 18'h00000;
    sel_blink   = 1'b0;
    unique case (grant)
      3'b001: begin
        sel_pattern = req_pattern0;
        sel_blink   = req_blink[0];
      end
      3'b010: begin
        sel_pattern = req_pattern1;
        sel_blink   = req_blink[1];
      end
      3'b100: begin
        sel_pattern = req_pattern2;
        sel_blink   = req_blink[2];
      end
      default: begin
        sel_pattern = 18'h00000;
        sel_blink   = 1'b0;
      end
    endcase
    displayed = sel_blink ? (sel_pattern & {18{blink_phase}}) : sel_pattern;
  end

  assign load_write = (state == ST_IDLE) && (displayed != shadow);

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Write FSM next state and bus strobes; WRITE lasts exactly one cycle
  // because the PIO accepts writes with zero wait states.
  always_comb begin
    next_state     = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'b00;
    busy           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (displayed != shadow) begin
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        busy           = 1'b1;
        next_state     = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the pattern being written and remember it as the PIO contents;
  // writedata then holds while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_writedata <= 32'h00000000;
      shadow        <= 18'h00000;
    end else if (load_write) begin
      avm_writedata <= {14'b0, displayed};
      shadow        <= displayed;
    end
  end

endmodule

// File: tb/tb_redled_display_arbiter.sv
// Directed testbench for redled_display_arbiter with a small PIO model.
module tb_redled_display_arbiter;

  localparam int BLINK_DIV   = 4;
  localparam int HOLD_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  req_valid = 3'b000;
  logic [17:0] req_pattern0 = 18'h0;
  logic [17:0] req_pattern1 = 18'h0;
  logic [17:0] req_pattern2 = 18'h0;
  logic [2:0]  req_blink = 3'b000;
  logic [2:0]  grant;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  redled_display_arbiter #(
    .BLINK_DIV  (BLINK_DIV),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_pattern0  (req_pattern0),
    .req_pattern1  (req_pattern1),
    .req_pattern2  (req_pattern2),
    .req_blink     (req_blink),
    .grant         (grant),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // PIO model: latches register 0 on each write strobe, counts writes and
  // flags strobes in consecutive cycles or nonzero upper data bits.
  logic        strobe;
  logic        prev_strobe;
  logic [17:0] pio_value;
  int          write_count;
  int          back_to_back_err;
  int          upper_err;

  assign strobe = avm_chipselect && !avm_write_n && (avm_address == 2'b00);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_value        <= 18'h0;
      write_count      <= 0;
      back_to_back_err <= 0;
      upper_err        <= 0;
      prev_strobe      <= 1'b0;
    end else begin
      prev_strobe <= strobe;
      if (strobe) begin
        pio_value   <= avm_writedata[17:0];
        write_count <= write_count + 1;
        if (prev_strobe) back_to_back_err <= back_to_back_err + 1;
        if (avm_writedata[31:18] != 14'h0) upper_err <= upper_err + 1;
      end
    end
  end

  task automatic test_reset();
    int seen;
    req_valid = 3'b000;
    req_blink = 3'b000;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected %b", grant, 3'b000); end
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL reset_cs: got %b expected 0", avm_chipselect); end
    checks++; if (avm_write_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_write_n: got %b expected 1", avm_write_n); end
    checks++; if (avm_address !== 2'b00) begin errors++; $display("[TB] FAIL reset_address: got %b expected 00", avm_address); end
    checks++; if (avm_writedata !== 32'h0) begin errors++; $display("[TB] FAIL reset_writedata: got %h expected %h", avm_writedata, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (avm_chipselect !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL idle_no_strobe: got %0d strobe cycles expected 0", seen); end
    checks++; if (write_count != 0) begin errors++; $display("[TB] FAIL idle_write_count: got %0d expected 0", write_count); end
    checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL idle_grant: got %b expected 000", grant); end
    checks++; if (avm_write_n !== 1'b1) begin errors++; $display("[TB] FAIL idle_write_n: got %b expected 1", avm_write_n); end
  endtask

  task automatic test_single_request();
    int start;
    start = write_count;
    req_pattern2 = 18'h00F0F;
    req_valid = 3'b100;
    @(negedge clk);
    checks++; if (grant !== 3'b100) begin errors++; $display("[TB] FAIL single_grant: got %b expected 100", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_early: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_strobe: got cs=%b wn=%b busy=%b expected cs=1 wn=0 busy=1", avm_chipselect, avm_write_n, busy); end
    checks++; if (avm_writedata !== 32'h00000F0F) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", avm_writedata, 32'h00000F0F); end
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_strobe_end: got cs=%b busy=%b expected 0 0", avm_chipselect, busy); end
    checks++; if (pio_value !== 18'h00F0F) begin errors++; $display("[TB] FAIL single_pio: got %h expected %h", pio_value, 18'h00F0F); end
    repeat (20) @(negedge clk);
    checks++; if (write_count - start != 1) begin errors++; $display("[TB] FAIL single_write_count: got %0d expected 1", write_count - start); end
    checks++; if (avm_writedata !== 32'h00000F0F) begin errors++; $display("[TB] FAIL single_data_hold: got %h expected %h", avm_writedata, 32'h00000F0F); end
  endtask

  task automatic test_drop_to_idle();
    int start;
    start = write_count;
    req_valid = 3'b000;
    @(negedge clk);
    checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL drop_idle_grant: got %b expected 000", grant); end
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b1 || avm_writedata !== 32'h0) begin errors++; $display("[TB] FAIL drop_idle_write: got cs=%b data=%h expected cs=1 data=%h", avm_chipselect, avm_writedata, 32'h0); end
    @(negedge clk);
    checks++; if (pio_value !== 18'h0 || write_count - start != 1) begin errors++; $display("[TB] FAIL drop_idle_pio: got pio=%h writes=%0d expected pio=0 writes=1", pio_value, write_count - start); end
  endtask

  task automatic test_hold_preempt();
    req_pattern2 = 18'h00AAA;
    req_pattern0 = 18'h15555;
    req_valid = 3'b100;
    @(negedge clk);
    checks++; if (grant !== 3'b100) begin errors++; $display("[TB] FAIL hold_initial_grant: got %b expected 100", grant); end
    for (int i = 1; i < HOLD_CYCLES; i++) begin
      @(negedge clk);
      checks++; if (grant !== 3'b100) begin errors++; $display("[TB] FAIL hold_keep_%0d: got %b expected 100", i, grant); end
      if (i == 3) req_valid = 3'b101;
    end
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL hold_preempt: got %b expected 001", grant); end
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b1 || avm_writedata !== 32'h00015555) begin errors++; $display("[TB] FAIL hold_preempt_write: got cs=%b data=%h expected cs=1 data=%h", avm_chipselect, avm_writedata, 32'h00015555); end
  endtask

  task automatic test_drop_regrant();
    req_valid = 3'b100;
    @(negedge clk);
    checks++; if (grant !== 3'b100) begin errors++; $display("[TB] FAIL regrant_grant: got %b expected 100", grant); end
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b1 || avm_writedata !== 32'h00000AAA) begin errors++; $display("[TB] FAIL regrant_write: got cs=%b data=%h expected cs=1 data=%h", avm_chipselect, avm_writedata, 32'h00000AAA); end
  endtask

  task automatic test_blink();
    logic        exp_strobe;
    logic [31:0] exp_data;
    req_valid = 3'b000;
    repeat (4) @(negedge clk);
    req_pattern1 = 18'h3FFFF;
    req_blink = 3'b010;
    req_valid = 3'b010;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_strobe = (i % 4 == 1);
      exp_data = (((i / 4) % 2) == 0) ? 32'h0003FFFF : 32'h00000000;
      checks++; if (avm_chipselect !== exp_strobe) begin errors++; $display("[TB] FAIL blink_strobe_%0d: got %b expected %b", i, avm_chipselect, exp_strobe); end
      if (exp_strobe) begin
        checks++; if (avm_writedata !== exp_data) begin errors++; $display("[TB] FAIL blink_data_%0d: got %h expected %h", i, avm_writedata, exp_data); end
      end
    end
    req_valid = 3'b000;
    req_blink = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int start;
    req_pattern0 = 18'h00001;
    req_valid = 3'b001;
    repeat (4) @(negedge clk);
    start = write_count;
    req_pattern0 = 18'h11111;
    @(negedge clk);
    req_pattern0 = 18'h22222;
    @(negedge clk);
    req_pattern0 = 18'h33333;
    @(negedge clk);
    req_pattern0 = 18'h04444;
    repeat (4) @(negedge clk);
    checks++; if (write_count - start != 3) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d expected 3", write_count - start); end
    checks++; if (pio_value !== 18'h04444) begin errors++; $display("[TB] FAIL b2b_final_pio: got %h expected %h", pio_value, 18'h04444); end
    checks++; if (back_to_back_err != 0) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d consecutive strobes expected 0", back_to_back_err); end
    checks++; if (upper_err != 0) begin errors++; $display("[TB] FAIL upper_bits: got %0d nonzero writes expected 0", upper_err); end
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL b2b_settled: got cs=%b expected 0", avm_chipselect); end
  endtask

  task automatic test_reset_mid_write();
    req_pattern0 = 18'h2AAAA;
    @(posedge clk);
    #2;
    checks++; if (avm_chipselect !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midwrite_active: got cs=%b busy=%b expected 1 1", avm_chipselect, busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midwrite_strobe_drop: got cs=%b wn=%b busy=%b expected 0 1 0", avm_chipselect, avm_write_n, busy); end
    checks++; if (grant !== 3'b000 || avm_writedata !== 32'h0 || avm_address !== 2'b00) begin errors++; $display("[TB] FAIL midwrite_reset_vals: got grant=%b data=%h addr=%b expected 000 %h 00", grant, avm_writedata, avm_address, 32'h0); end
    req_valid = 3'b000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (write_count != 0 || grant !== 3'b000) begin errors++; $display("[TB] FAIL post_reset_idle: got writes=%0d grant=%b expected 0 000", write_count, grant); end
    checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_bus: got cs=%b wn=%b expected 0 1", avm_chipselect, avm_write_n); end
  endtask

  initial begin
    $display("[TB] starting redled_display_arbiter bench");
    test_reset();
    test_single_request();
    test_drop_to_idle();
    test_hold_preempt();
    test_drop_regrant();
    test_blink();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
